key_cmd_ctrl: RTL and testbench

//  Key-command sequencer for the debugger front panel. Consumes the synchronized

---
 rtl/key_cmd_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_cmd_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_ctrl.sv
// Front-panel key-command sequencer: classifies single-key presses as short, long
// or auto-repeat and hands them to the debugger core through a one-entry output register.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | no key down, armed for a new press
//  PRESS    | single key held, counting toward the long-press threshold
//  REPEAT   | long command issued, counting toward the next auto-repeat
//  WAIT_REL | press finished or chord seen, waiting for all keys released
module key_cmd_ctrl #(
    parameter int LONG_CYC   = 1000,
    parameter int REPEAT_CYC = 200,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_level,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_key,
    output logic       cmd_long,
    output logic       cmd_repeat,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT, WAIT_REL} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       key, key_nxt;
    logic [1:0]       press_idx;
    logic             onehot, held, released;
    logic             issue, issue_long, issue_rep;

    assign onehot   = (sw_level != 4'd0) && ((sw_level & (sw_level - 4'd1)) == 4'd0);
    assign held     = (sw_level == (4'b0001 << key));
    assign released = (sw_level == 4'd0);
    assign busy     = (state != IDLE);

    always_comb begin
        press_idx = 2'd0;
        case (sw_level)
            4'b0010: press_idx = 2'd1;
            4'b0100: press_idx = 2'd2;
            4'b1000: press_idx = 2'd3;
            default: press_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        key_nxt    = key;
        issue      = 1'b0;
        issue_long = 1'b0;
        issue_rep  = 1'b0;
        case (state)
            IDLE: begin
                if (onehot) begin
                    key_nxt   = press_idx;
                    cnt_nxt   = '0;
                    state_nxt = PRESS;
                end else if (!released) begin
                    state_nxt = WAIT_REL;
                end
            end
            PRESS: begin
                if (held) begin
                    if (cnt == LONG_LAST) begin
                        issue      = 1'b1;
                        issue_long = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = REPEAT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (released) begin
                    issue     = 1'b1;
                    state_nxt = WAIT_REL;
                end else begin
                    state_nxt = WAIT_REL;
                end
            end
            REPEAT: begin
                if (held) begin
                    if (cnt == REPEAT_LAST) begin
                        issue      = 1'b1;
                        issue_long = 1'b1;
                        issue_rep  = 1'b1;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (released) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            key   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            key   <= key_nxt;
        end
    end

    // The FSM never waits on the core: a command arriving while one is still
    // pending and not being taken this cycle is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_key    <= 2'd0;
            cmd_long   <= 1'b0;
            cmd_repeat <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (issue) begin
                if (!cmd_valid || cmd_ready) begin
                    cmd_valid  <= 1'b1;
                    cmd_key    <= key;
                    cmd_long   <= issue_long;
                    cmd_repeat <= issue_rep;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl with short thresholds (long after 8, repeat every 4).
module tb_key_cmd_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] sw_level;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_key;
    logic       cmd_long;
    logic       cmd_repeat;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    key_cmd_ctrl #(.LONG_CYC(8), .REPEAT_CYC(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_level   (sw_level),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_key    (cmd_key),
        .cmd_long   (cmd_long),
        .cmd_repeat (cmd_repeat),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},   {31'd0, cmd_valid},  32'd0);
        check({tag, "_overrun"}, {31'd0, overrun},    32'd0);
        check({tag, "_busy"},    {31'd0, busy},       32'd0);
        check({tag, "_payload"}, {28'd0, cmd_key, cmd_long, cmd_repeat}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        sw_level  = 4'd0;
        cmd_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        #2 reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Short press of key 0
        sw_level = 4'b0001;
        tick();
        check("short_busy_press", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check("short_no_cmd_held", {31'd0, cmd_valid}, 32'd0);
        sw_level = 4'b0000;
        tick();
        check("short_valid", {31'd0, cmd_valid}, 32'd1);
        check("short_payload", {28'd0, cmd_key, cmd_long, cmd_repeat}, 32'd0);
        check("short_busy_wait", {31'd0, busy}, 32'd1);
        tick();
        check("short_valid_drop", {31'd0, cmd_valid}, 32'd0);
        check("short_busy_idle", {31'd0, busy}, 32'd0);

        // Long press of key 2 with auto-repeat, ready always high
        sw_level = 4'b0100;
        tick();
        check("long_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 8 || k == 12 || k == 16 || k == 20) begin
                check($sformatf("long_valid_%0d", k), {31'd0, cmd_valid}, 32'd1);
                check($sformatf("long_payload_%0d", k), {28'd0, cmd_key, cmd_long, cmd_repeat},
                      {28'd0, 2'd2, 1'b1, (k != 8)});
            end else begin
                check($sformatf("long_idle_%0d", k), {31'd0, cmd_valid}, 32'd0);
            end
            check($sformatf("long_overrun_%0d", k), {31'd0, overrun}, 32'd0);
        end
        sw_level = 4'b0000;
        tick();
        check("long_release_nocmd", {31'd0, cmd_valid}, 32'd0);
        check("long_release_busy", {31'd0, busy}, 32'd1);
        tick();
        check("long_idle", {31'd0, busy}, 32'd0);
        check("long_idle_valid", {31'd0, cmd_valid}, 32'd0);

        // Chord during PRESS, then chord straight from IDLE
        sw_level = 4'b0001;
        tick();
        tick();
        tick();
        sw_level = 4'b0011;
        tick();
        check("chord_busy", {31'd0, busy}, 32'd1);
        check("chord_nocmd", {31'd0, cmd_valid}, 32'd0);
        sw_level = 4'b0000;
        tick();
        check("chord_idle", {31'd0, busy}, 32'd0);
        check("chord_nocmd2", {31'd0, cmd_valid}, 32'd0);
        sw_level = 4'b1001;
        tick();
        check("chord2_busy", {31'd0, busy}, 32'd1);
        check("chord2_nocmd", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("chord2_hold_busy", {31'd0, busy}, 32'd1);
        sw_level = 4'b0000;
        tick();
        check("chord2_idle", {31'd0, busy}, 32'd0);
        check("chord2_nocmd2", {31'd0, cmd_valid}, 32'd0);

        // Backpressure with key 3
        cmd_ready = 1'b0;
        sw_level  = 4'b1000;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("bp_valid_%0d", k), {31'd0, cmd_valid}, {31'd0, (k >= 8)});
            check($sformatf("bp_overrun_%0d", k), {31'd0, overrun},
                  {31'd0, (k == 12 || k == 16 || k == 20)});
            if (k >= 8)
                check($sformatf("bp_payload_%0d", k), {28'd0, cmd_key, cmd_long, cmd_repeat},
                      {28'd0, 2'd3, 1'b1, 1'b0});
        end
        sw_level = 4'b0000;
        tick();
        check("bp_still_pending", {31'd0, cmd_valid}, 32'd1);
        check("bp_no_overrun", {31'd0, overrun}, 32'd0);
        cmd_ready = 1'b1;
        tick();
        check("bp_drain", {31'd0, cmd_valid}, 32'd0);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Reset mid-hold with a pending command
        cmd_ready = 1'b0;
        sw_level  = 4'b0001;
        tick();
        sw_level = 4'b0000;
        tick();
        check("rst_pending_valid", {31'd0, cmd_valid}, 32'd1);
        tick();
        sw_level = 4'b0010;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        check("rst_pre_valid", {31'd0, cmd_valid}, 32'd1);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        #2 reset = 1'b0;
        cmd_ready = 1'b1;
        tick();
        check("rst_fresh_press", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 7; k++) tick();
        check("rst_not_yet", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("rst_long_valid", {31'd0, cmd_valid}, 32'd1);
        check("rst_long_payload", {28'd0, cmd_key, cmd_long, cmd_repeat},
              {28'd0, 2'd1, 1'b1, 1'b0});
        sw_level = 4'b0000;
        tick();
        tick();
        check("end_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
